seg7_pattern_decoder: RTL and testbench

Inverse of the board's hex-to-segment encoder: samples an active-low 7-segment pattern bus (as driven onto HEXn pins) and recovers the 4-bit hex digit it shows. A pattern is published only after it has been stable for a programmable number of cycles, so multiplexing glitches and mid-update transients are filtered out. Used in self-check and readback paths of the clock design to confirm what each display is actually showing, and counts illegal patterns for debug.

---
 rtl/seg7_pattern_decoder.sv | 194 +++++++++++++++++++
 tb/tb_seg7_pattern_decoder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_pattern_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pattern_decoder
// Purpose  : Recovers the hex digit shown on an active-low 7-segment bus.
//            A pattern is published only after it has been sampled
//            STABLE_CYCLES times in a row, which filters multiplexing
//            glitches and mid-update transients. Illegal published patterns
//            are counted (saturating) for debug.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous, active-high reset
//            pattern    - active-low segments, bit0=a .. bit6=g
//            clear_err  - synchronous clear of err_count
//            digit      - last published digit value
//            valid      - published pattern is a legal hex digit
//            blank      - published pattern is all-off (7'h7F)
//            update     - one-cycle pulse on every publish
//            err_count  - saturating count of illegal publishes
// Revision : 1.0 - initial release
// ============================================================================
module seg7_pattern_decoder #(
    parameter int STABLE_CYCLES = 4,   // legal range 1..255
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       pattern,
    input  logic             clear_err,
    output logic [3:0]       digit,
    output logic             valid,
    output logic             blank,
    output logic             update,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [7:0]       c_stable     = 8'(STABLE_CYCLES);
    localparam logic [6:0]       c_blank_code = 7'h7F;
    localparam logic [ERR_W-1:0] c_err_max    = '1;
    localparam logic [ERR_W-1:0] c_err_one    = ERR_W'(1);

    localparam logic [0:0] c_settle = 1'b0;
    localparam logic [0:0] c_locked = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [6:0]       r_samp;
    logic [7:0]       r_run;
    logic [3:0]       r_digit;
    logic             r_valid;
    logic             r_blank;
    logic             r_update;
    logic [ERR_W-1:0] r_err;

    logic             w_match;
    logic             w_publish;
    logic [3:0]       w_dec_digit;
    logic             w_dec_legal;
    logic             w_dec_blank;

    assign w_match = (pattern == r_samp);

    // ------------------------------------------------------------------
    // Sample register and stability run counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_samp <= c_blank_code;
            r_run  <= 8'd0;
        end else begin
            r_samp <= pattern;
            if (w_match) begin
                r_run <= (r_run >= c_stable) ? c_stable : r_run + 8'd1;
            end else begin
                r_run <= 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_settle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // If the input moves on the very edge we publish, the new value has
    // already started its own run, so stay in SETTLE to publish it later.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_settle: begin
                if (r_run == c_stable) begin
                    w_state_next = w_match ? c_locked : c_settle;
                end
            end
            c_locked: begin
                if (!w_match) begin
                    w_state_next = c_settle;
                end
            end
            default: w_state_next = c_settle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (publish strobe and pattern decode of r_samp)
    // ------------------------------------------------------------------
    always_comb begin
        w_publish   = (r_state == c_settle) && (r_run == c_stable);
        w_dec_blank = (r_samp == c_blank_code);
        w_dec_digit = 4'h0;
        w_dec_legal = 1'b1;
        case (r_samp)
            7'h40:   w_dec_digit = 4'h0;
            7'h79:   w_dec_digit = 4'h1;
            7'h24:   w_dec_digit = 4'h2;
            7'h30:   w_dec_digit = 4'h3;
            7'h19:   w_dec_digit = 4'h4;
            7'h12:   w_dec_digit = 4'h5;
            7'h02:   w_dec_digit = 4'h6;
            7'h78:   w_dec_digit = 4'h7;
            7'h00:   w_dec_digit = 4'h8;
            7'h10:   w_dec_digit = 4'h9;
            7'h20:   w_dec_digit = 4'hA;
            7'h03:   w_dec_digit = 4'hB;
            7'h46:   w_dec_digit = 4'hC;
            7'h21:   w_dec_digit = 4'hD;
            7'h06:   w_dec_digit = 4'hE;
            7'h0E:   w_dec_digit = 4'hF;
            default: w_dec_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Published outputs; held between publishes
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digit  <= 4'h0;
            r_valid  <= 1'b0;
            r_blank  <= 1'b0;
            r_update <= 1'b0;
        end else begin
            r_update <= w_publish;
            if (w_publish) begin
                if (w_dec_legal) begin
                    r_digit <= w_dec_digit;
                    r_valid <= 1'b1;
                    r_blank <= 1'b0;
                end else if (w_dec_blank) begin
                    r_digit <= 4'h0;
                    r_valid <= 1'b0;
                    r_blank <= 1'b1;
                end else begin
                    // Illegal code: digit keeps the last good value
                    r_valid <= 1'b0;
                    r_blank <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Illegal-pattern counter; a clear coinciding with an illegal publish
    // leaves that publish counted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= '0;
        end else if (w_publish && !w_dec_legal && !w_dec_blank) begin
            if (clear_err) begin
                r_err <= c_err_one;
            end else if (r_err != c_err_max) begin
                r_err <= r_err + c_err_one;
            end
        end else if (clear_err) begin
            r_err <= '0;
        end
    end

    assign digit     = r_digit;
    assign valid     = r_valid;
    assign blank     = r_blank;
    assign update    = r_update;
    assign err_count = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seg7_pattern_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_pattern_decoder
// Purpose  : Self-checking bench. Two instances share one stimulus stream:
//            A (STABLE_CYCLES=4, ERR_W=8) and B (STABLE_CYCLES=1, ERR_W=2).
//            The reference model states the behaviour as "a value sampled
//            S times in a row is published on the following edge".
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_pattern_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] pattern = 7'h7F;
    logic       clear_err = 1'b0;

    logic [3:0] digit_a, digit_b;
    logic       valid_a, valid_b, blank_a, blank_b, update_a, update_b;
    logic [7:0] err_a;
    logic [1:0] err_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_pattern_decoder #(.STABLE_CYCLES(4), .ERR_W(8)) dut_a (
        .clk(clk), .reset(reset), .pattern(pattern), .clear_err(clear_err),
        .digit(digit_a), .valid(valid_a), .blank(blank_a),
        .update(update_a), .err_count(err_a)
    );

    seg7_pattern_decoder #(.STABLE_CYCLES(1), .ERR_W(2)) dut_b (
        .clk(clk), .reset(reset), .pattern(pattern), .clear_err(clear_err),
        .digit(digit_b), .valid(valid_b), .blank(blank_b),
        .update(update_b), .err_count(err_b)
    );

    // ---------------- reference model ----------------
    logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h20, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int s_of   [2] = '{4, 1};
    int errmax [2] = '{255, 3};

    int         streak [2];
    logic [6:0] last   [2];
    logic [3:0] m_digit[2];
    logic       m_valid[2];
    logic       m_blank[2];
    logic       m_upd  [2];
    int         m_err  [2];

    function automatic int lookup(input logic [6:0] code);
        for (int k = 0; k < 16; k++) begin
            if (codes[k] == code) return k;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                streak[i]  <= 0;
                last[i]    <= 7'h7F;
                m_digit[i] <= 4'h0;
                m_valid[i] <= 1'b0;
                m_blank[i] <= 1'b0;
                m_upd[i]   <= 1'b0;
                m_err[i]   <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_upd[i] <= (streak[i] == s_of[i]);
                if (streak[i] == s_of[i] && lookup(last[i]) >= 0) begin
                    m_digit[i] <= 4'(lookup(last[i]));
                    m_valid[i] <= 1'b1;
                    m_blank[i] <= 1'b0;
                end else if (streak[i] == s_of[i] && last[i] == 7'h7F) begin
                    m_digit[i] <= 4'h0;
                    m_valid[i] <= 1'b0;
                    m_blank[i] <= 1'b1;
                end else if (streak[i] == s_of[i]) begin
                    m_valid[i] <= 1'b0;
                    m_blank[i] <= 1'b0;
                end
                if (streak[i] == s_of[i] && lookup(last[i]) < 0 && last[i] != 7'h7F) begin
                    if (clear_err) m_err[i] <= 1;
                    else m_err[i] <= (m_err[i] + 1 > errmax[i]) ? errmax[i] : m_err[i] + 1;
                end else if (clear_err) begin
                    m_err[i] <= 0;
                end
                streak[i] <= (pattern == last[i]) ? streak[i] + 1 : 1;
                last[i]   <= pattern;
            end
        end
    end

    logic [14:0] obs_a, exp_a;
    logic [8:0]  obs_b, exp_b;
    int          m_err_a, m_err_b;
    assign m_err_a = m_err[0];
    assign m_err_b = m_err[1];
    assign obs_a = {digit_a, valid_a, blank_a, update_a, err_a};
    assign obs_b = {digit_b, valid_b, blank_b, update_b, err_b};
    assign exp_a = {m_digit[0], m_valid[0], m_blank[0], m_upd[0], m_err_a[7:0]};
    assign exp_b = {m_digit[1], m_valid[1], m_blank[1], m_upd[1], m_err_b[1:0]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int ups;
        ups = 0;
        pattern = 7'h7F;
        #2 reset = 1'b1;
        tick();
        tick();
        checks++;
        if (obs_a !== 15'h0 || obs_b !== 9'h0) begin
            errors++;
            $display("FAIL reset_state a=%h b=%h required 0", obs_a, obs_b);
        end
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (update_a) ups++;
            checks++;
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                errors++;
                $display("FAIL reset_idle c=%0d a=%h/%h b=%h/%h", c, obs_a, exp_a, obs_b, exp_b);
            end
        end
        checks++;
        if (ups != 1 || blank_a !== 1'b1 || valid_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_pulse ups=%0d blank=%b valid=%b required 1,1,0", ups, blank_a, valid_a);
        end
    endtask

    task automatic test_sweep();
        int ups_a, ups_b;
        ups_a = 0;
        ups_b = 0;
        for (int d = 0; d < 16; d++) begin
            pattern = codes[d];
            for (int c = 0; c < 6; c++) begin
                tick();
                if (update_a) ups_a++;
                if (update_b) ups_b++;
                checks++;
                if (obs_a !== exp_a || obs_b !== exp_b) begin
                    errors++;
                    $display("FAIL sweep d=%0d c=%0d a=%h/%h b=%h/%h", d, c, obs_a, exp_a, obs_b, exp_b);
                end
            end
        end
        checks++;
        if (ups_a != 16 || ups_b != 16 || digit_a !== 4'hF || valid_a !== 1'b1 || err_a !== 8'd0) begin
            errors++;
            $display("FAIL sweep_end ups=%0d/%0d digit=%h valid=%b err=%0d required 16/16 F 1 0",
                     ups_a, ups_b, digit_a, valid_a, err_a);
        end
    endtask

    task automatic test_glitch();
        int ups;
        logic [6:0] seq [3] = '{7'h24, 7'h30, 7'h24};
        int         len [3] = '{6, 2, 6};
        ups = 0;
        for (int s = 0; s < 3; s++) begin
            pattern = seq[s];
            for (int c = 0; c < len[s]; c++) begin
                tick();
                if (s > 0 && update_a) ups++;
                checks++;
                if (obs_a !== exp_a || obs_b !== exp_b) begin
                    errors++;
                    $display("FAIL glitch s=%0d c=%0d a=%h/%h b=%h/%h", s, c, obs_a, exp_a, obs_b, exp_b);
                end
            end
        end
        checks++;
        if (ups != 1 || digit_a !== 4'h2 || valid_a !== 1'b1 || err_a !== 8'd0) begin
            errors++;
            $display("FAIL glitch_end ups=%0d digit=%h valid=%b err=%0d required 1 2 1 0", ups, digit_a, valid_a, err_a);
        end
    endtask

    task automatic test_illegal();
        pattern = 7'h7E;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                errors++;
                $display("FAIL illegal c=%0d a=%h/%h b=%h/%h", c, obs_a, exp_a, obs_b, exp_b);
            end
        end
        checks++;
        if (err_a !== 8'd1 || digit_a !== 4'h2 || valid_a !== 1'b0 || blank_a !== 1'b0) begin
            errors++;
            $display("FAIL illegal_end err=%0d digit=%h valid=%b blank=%b required 1 2 0 0",
                     err_a, digit_a, valid_a, blank_a);
        end
        pattern   = 7'h7D;
        clear_err = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                errors++;
                $display("FAIL clear_illegal c=%0d a=%h/%h b=%h/%h", c, obs_a, exp_a, obs_b, exp_b);
            end
        end
        clear_err = 1'b0;
        checks++;
        if (err_a !== 8'd1 || err_b !== 2'd0) begin
            errors++;
            $display("FAIL clear_illegal_end err_a=%0d err_b=%0d required 1 0", err_a, err_b);
        end
    endtask

    task automatic test_saturation();
        logic [6:0] bad [5] = '{7'h7E, 7'h7D, 7'h7B, 7'h77, 7'h6F};
        for (int p = 0; p < 5; p++) begin
            pattern = bad[p];
            for (int c = 0; c < 5; c++) begin
                tick();
                checks++;
                if (obs_a !== exp_a || obs_b !== exp_b) begin
                    errors++;
                    $display("FAIL saturation p=%0d c=%0d a=%h/%h b=%h/%h", p, c, obs_a, exp_a, obs_b, exp_b);
                end
            end
        end
        checks++;
        if (err_b !== 2'd3 || err_a !== 8'd6) begin
            errors++;
            $display("FAIL saturation_end err_b=%0d err_a=%0d required 3 6", err_b, err_a);
        end
    endtask

    task automatic test_random();
        int sel, hold;
        for (int n = 0; n < 40; n++) begin
            sel  = $urandom_range(0, 3);
            hold = $urandom_range(1, 7);
            if (sel < 2)       pattern = codes[$urandom_range(0, 15)];
            else if (sel == 2) pattern = 7'h7F;
            else               pattern = 7'($urandom);
            clear_err = ($urandom_range(0, 7) == 0);
            for (int c = 0; c < hold; c++) begin
                tick();
                checks++;
                if (obs_a !== exp_a || obs_b !== exp_b) begin
                    errors++;
                    $display("FAIL random n=%0d c=%0d pat=%h a=%h/%h b=%h/%h",
                             n, c, pattern, obs_a, exp_a, obs_b, exp_b);
                end
            end
        end
        clear_err = 1'b0;
    endtask

    task automatic test_async_reset();
        pattern = 7'h40;
        for (int c = 0; c < 6; c++) tick();
        pattern = 7'h19;
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs_a !== 15'h0 || obs_b !== 9'h0) begin
            errors++;
            $display("FAIL async_reset a=%h b=%h required 0", obs_a, obs_b);
        end
        #1 reset = 1'b0;
        for (int c = 0; c < 7; c++) begin
            tick();
            checks++;
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                errors++;
                $display("FAIL async_relock c=%0d a=%h/%h b=%h/%h", c, obs_a, exp_a, obs_b, exp_b);
            end
        end
        checks++;
        if (digit_a !== 4'h4 || valid_a !== 1'b1) begin
            errors++;
            $display("FAIL async_relock_end digit=%h valid=%b required 4 1", digit_a, valid_a);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_glitch();
        test_illegal();
        test_saturation();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
